// File: rtl/sand_pkg.sv
// Shared constants and types for the sand simulator register map and cell layout.
// Latency: none (package only).
// Backpressure: not applicable.
package sand_pkg;

  // Particle kinds stored two bits per cell.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    SAND  = 2'd1,
    WALL  = 2'd2,
    WATER = 2'd3
  } particle_t;

  localparam int ROW_WORDS      = 80;
  localparam int ROWS           = 480;
  localparam int COLS           = 640;
  localparam int CELLS_PER_WORD = 8;

  // HPS register map
  localparam logic [2:0] REG_X     = 3'd0;
  localparam logic [2:0] REG_Y     = 3'd1;
  localparam logic [2:0] REG_TYPE  = 3'd2;
  localparam logic [2:0] REG_GO    = 3'd3;
  localparam logic [2:0] REG_CLEAR = 3'd4;

  // Last word of the cell map; the clear sweep stops here.
  localparam logic [23:0] LAST_WORD = 24'(ROW_WORDS * ROWS - 1);

  // Word holding cell (x, y): eight cells per word, 80 words per row.
  function automatic logic [23:0] cell_word_addr(input logic [9:0] x, input logic [8:0] y);
    return 24'(y) * 24'(ROW_WORDS) + 24'(x[9:3]);
  endfunction

endpackage

// File: rtl/sand_cell_merge.sv
// Replaces one 2-bit cell inside a 16-bit map word; cell 0 sits in the top bits.
// Latency: combinational.
// Backpressure: none.
module sand_cell_merge
  import sand_pkg::*;
(
  input  logic [15:0] word_in,
  input  logic [2:0]  cell_idx,
  input  particle_t   cell_type,
  output logic [15:0] word_out
);

  logic [3:0]  shift;
  logic [15:0] mask;

  // Clear the selected cell's two bits and drop the new type into them.
  always_comb begin
    shift    = 4'd14 - {cell_idx, 1'b0};
    mask     = 16'h0003 << shift;
    word_out = (word_in & ~mask) | ({14'd0, cell_type} << shift);
  end

endmodule

// File: rtl/sand_brush.sv
// Brush: read-modify-write of one cell (GO), or zero-fill of the whole map (CLEAR, only with SAND_BRUSH_CLEAR_EN).
// Latency: bus_req the cycle after acceptance; then grant wait, one read, one write, one DONE cycle.
// Backpressure: strobes held while mem_waitrequest; commands arriving while not idle are dropped with cmd_dropped.
module sand_brush
  import sand_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        kernel_chipselect,
  input  logic        kernel_write,
  input  logic [2:0]  kernel_address,
  input  logic [15:0] kernel_writedata,
  output logic        bus_req,
  input  logic        bus_grant,
  output logic [23:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  input  logic        mem_waitrequest,
  input  logic        mem_readdatavalid,
  input  logic [15:0] mem_readdata,
  output logic [15:0] mem_writedata,
  output logic        busy,
  output logic        cmd_dropped
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RD,
    S_RDW,
    S_WR,
`ifdef SAND_BRUSH_CLEAR_EN
    S_CLR,
`endif
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [9:0]  x_q;
  logic [8:0]  y_q;
  particle_t   type_q;
  logic [2:0]  op_k_q;
  particle_t   op_type_q;
  logic [15:0] merged_word;

  logic reg_wr, go_wr, clr_wr, go_accept, clr_accept, drop;
`ifdef SAND_BRUSH_CLEAR_EN
  logic op_clr_q;
`endif

  // Upper payload bits carry no register state.
  logic unused_ok;
  assign unused_ok = &{1'b0, kernel_writedata[15:10]};

  // Decode register strobes and decide accept or drop for commands.
  always_comb begin
    reg_wr    = kernel_chipselect & kernel_write;
    go_wr     = reg_wr && (kernel_address == REG_GO);
    clr_wr    = reg_wr && (kernel_address == REG_CLEAR);
    go_accept = go_wr && (state_q == S_IDLE) && (x_q < 10'(COLS)) && (y_q < 9'(ROWS));
`ifdef SAND_BRUSH_CLEAR_EN
    clr_accept = clr_wr && (state_q == S_IDLE);
`else
    clr_accept = 1'b0;
`endif
    drop = (go_wr && !go_accept) || (clr_wr && !clr_accept);
  end

  sand_cell_merge u_merge (
    .word_in   (mem_readdata),
    .cell_idx  (op_k_q),
    .cell_type (op_type_q),
    .word_out  (merged_word)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state and bus strobes, all decoded from the current state.
  always_comb begin
    state_d   = state_q;
    bus_req   = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (go_accept || clr_accept) state_d = S_REQ;
      end
      S_REQ: begin
        bus_req = 1'b1;
        busy    = 1'b1;
        if (bus_grant) begin
`ifdef SAND_BRUSH_CLEAR_EN
          state_d = op_clr_q ? S_CLR : S_RD;
`else
          state_d = S_RD;
`endif
        end
      end
      S_RD: begin
        bus_req  = 1'b1;
        busy     = 1'b1;
        mem_read = 1'b1;
        if (!mem_waitrequest) state_d = S_RDW;
      end
      S_RDW: begin
        bus_req = 1'b1;
        busy    = 1'b1;
        if (mem_readdatavalid) state_d = S_WR;
      end
      S_WR: begin
        bus_req   = 1'b1;
        busy      = 1'b1;
        mem_write = 1'b1;
        if (!mem_waitrequest) state_d = S_DONE;
      end
`ifdef SAND_BRUSH_CLEAR_EN
      S_CLR: begin
        bus_req   = 1'b1;
        busy      = 1'b1;
        mem_write = 1'b1;
        if (!mem_waitrequest && (mem_address == LAST_WORD)) state_d = S_DONE;
      end
`endif
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Registers, per-operation copies, address/data outputs and the drop pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      x_q           <= '0;
      y_q           <= '0;
      type_q        <= EMPTY;
      op_k_q        <= '0;
      op_type_q     <= EMPTY;
      mem_address   <= '0;
      mem_writedata <= '0;
      cmd_dropped   <= 1'b0;
`ifdef SAND_BRUSH_CLEAR_EN
      op_clr_q      <= 1'b0;
`endif
    end else begin
      cmd_dropped <= drop;
      if (reg_wr) begin
        case (kernel_address)
          REG_X:    x_q    <= kernel_writedata[9:0];
          REG_Y:    y_q    <= kernel_writedata[8:0];
          REG_TYPE: type_q <= particle_t'(kernel_writedata[1:0]);
          default:  ;
        endcase
      end
      // Address and cell are frozen at acceptance so later register writes cannot disturb the operation.
      if (go_accept) begin
        mem_address <= cell_word_addr(x_q, y_q);
        op_k_q      <= x_q[2:0];
        op_type_q   <= type_q;
`ifdef SAND_BRUSH_CLEAR_EN
        op_clr_q    <= 1'b0;
`endif
      end
      if ((state_q == S_RDW) && mem_readdatavalid) mem_writedata <= merged_word;
`ifdef SAND_BRUSH_CLEAR_EN
      if (clr_accept) begin
        mem_address   <= '0;
        mem_writedata <= '0;
        op_clr_q      <= 1'b1;
      end
      // Sweep advances only on an accepted write and parks on the last word.
      if ((state_q == S_CLR) && !mem_waitrequest && (mem_address != LAST_WORD))
        mem_address <= mem_address + 24'd1;
`endif
    end
  end

endmodule

// File: doc/sand_brush.md
SAND_BRUSH -- requirements
Module: sand_brush

Interface
REQ-001 clock  input  1  system clock; all state changes on its rising edge.
REQ-002 reset  input  1  reset, synchronous, active-high.
REQ-003 kernel_chipselect  input  1  HPS slave select.
REQ-004 kernel_write  input  1  HPS write strobe; a register write occurs only when both chipselect and write are high.
REQ-005 kernel_address  input  3  register select: 0 X, 1 Y, 2 TYPE, 3 GO, 4 CLEAR.
REQ-006 kernel_writedata  input  16  register payload.
REQ-007 bus_req  output  1  request for the SDRAM master port from the sand_top arbiter.
REQ-008 bus_grant  input  1  arbiter grant; valid only while bus_req is high.
REQ-009 mem_address  output  24  SDRAM word address.
REQ-010 mem_read / mem_write  output  1 each  Avalon-MM read and write strobes.
REQ-011 mem_waitrequest  input  1  slave stall.
REQ-012 mem_readdatavalid  input  1  read data qualifier.
REQ-013 mem_readdata  input  16  read data.
REQ-014 mem_writedata  output  16  write data.
REQ-015 busy  output  1  high from GO/CLEAR acceptance until the bus is released.
REQ-016 cmd_dropped  output  1  one-cycle pulse when a GO or CLEAR is rejected.

Function
REQ-017 Registers X[9:0], Y[8:0], TYPE[1:0] SHALL load from the low writedata bits on any write, including while busy; an in-flight operation SHALL use copies latched at acceptance.
REQ-018 Cell map: word address = Y*80 + X[9:3]; the cell index k = X[2:0] occupies bits [15-2k:14-2k].
REQ-019 A GO write while IDLE with X<640 and Y<480 SHALL be accepted; bus_req rises the next cycle.
REQ-020 A GO or CLEAR write while busy, or a GO with out-of-range coordinates, SHALL be ignored and SHALL pulse cmd_dropped.
REQ-021 FSM: IDLE -> REQ (bus_req=1, wait grant) -> RD (mem_read=1, held while waitrequest) -> RDW (wait readdatavalid) -> WR (mem_write=1, held while waitrequest) -> DONE (bus_req=0, busy=0) -> IDLE.
REQ-022 In WR, mem_writedata SHALL equal the captured read word with only cell k replaced by TYPE; all other bits SHALL be unchanged.
REQ-023 mem_address SHALL be stable while a strobe is high; mem_read and mem_write SHALL never both be high.
REQ-024 If readdatavalid coincides with the cycle in which mem_read drops, the data SHALL be captured; RDW SHALL wait without a timeout.
REQ-025 CLEAR (REQ -> CLR) SHALL write 16'h0000 to addresses 0..38399 in order, holding each while waitrequest, and then go to DONE; the address counter SHALL NOT wrap past 38399.
REQ-026 If bus_grant drops mid-operation, strobes SHALL be completed as already issued; grant is sampled only in REQ.

Reset
REQ-027 Reset SHALL force: state IDLE, bus_req=0, mem_read=0, mem_write=0, mem_address=0, mem_writedata=0, busy=0, cmd_dropped=0, X=Y=TYPE=0.
REQ-028 Reset mid-operation SHALL abort the operation at the next edge with no further strobes; the partially cleared memory is left as is.

Configuration
REQ-029 SAND_BRUSH_CLEAR_EN defined: CLEAR behaves per REQ-025.
REQ-030 SAND_BRUSH_CLEAR_EN undefined: no CLR state and no clear counter exist; a CLEAR write SHALL only pulse cmd_dropped.

Structure
REQ-031 The shared package sand_pkg SHALL hold: particle enum (EMPTY=0, SAND=1, WALL=2, WATER=3), ROW_WORDS=80, ROWS=480, COLS=640, CELLS_PER_WORD=8, and the register address constants.
REQ-032 The combinational cell insert (word, k, type -> word) SHALL be a sub-module named sand_cell_merge.

Verification
REQ-033 X=13, Y=2, TYPE=2, GO; grant after 3 cycles; readdata=16'hFFFF -> read at address 161, then a write of 16'hFFEF to address 161.
REQ-034 X=0, Y=0, TYPE=1, readdata=16'h0000 -> write of 16'h4000 to address 0; X=639, Y=479, TYPE=3 -> write to address 38399 with bits [1:0]=11.
REQ-035 X=640, GO -> cmd_dropped pulses once, bus_req stays low.
REQ-036 GO during an operation with waitrequest held 5 cycles -> cmd_dropped pulses, the first operation completes, mem_address stays stable while stalled.
REQ-037 CLEAR with SAND_BRUSH_CLEAR_EN, random waitrequest -> exactly 38400 zero writes to addresses 0..38399, then busy=0; reset asserted after 100 writes -> all strobes low on the next cycle.
